seg7_sequence_checker: RTL and testbench

- Receiver-side monitor for the 7-segment output of the counter/display path.
- Takes the segment pattern driven to the display, qualifies it for stability, and decodes it back to a 4-bit value.
- Checks that successive accepted values follow the count sequence, with modulo wrap.
- Reports updates, sequence errors and illegal glyphs. Used on-chip for self-check and bring-up.

---
 rtl/seg7_sequence_checker.sv | 153 +++++++++++++++
 tb/tb_seg7_sequence_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_sequence_checker.sv
// Receiver-side monitor for an active-low 7-segment bus: stability filter,
// glyph decoder and count-sequence checker with modulo wrap.
module seg7_sequence_checker #(
    parameter int STABLE_CYCLES = 3,
    parameter int MOD           = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [3:0]       value_out,
    output logic             value_valid,
    output logic             update_pulse,
    output logic             seq_err,
    output logic             glyph_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] update_count
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);

    typedef enum logic {SYNC, TRACK} state_t;

    logic [6:0]       sample_q, sample_d;
    logic [6:0]       acc_q, acc_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             accept;
    logic             legal;
    logic [3:0]       dval;
    logic [3:0]       nxt;

    state_t           state_q;
    logic [3:0]       value_q;
    logic             valid_q;
    logic             up_q;
    logic             seq_q;
    logic             gly_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    // stab_q counts how many extra cycles sample_q has been repeated
    always_comb begin
        sample_d = seg_in;
        stab_d   = stab_q;
        if (seg_in != sample_q) begin
            stab_d = '0;
        end else if (stab_q != SMAX) begin
            stab_d = stab_q + 1'b1;
        end
        accept = (stab_q == SMAX) && (sample_q != acc_q);
        acc_d  = accept ? sample_q : acc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= 7'b1111111;
            acc_q    <= 7'b1111111;
            stab_q   <= '0;
        end else begin
            sample_q <= sample_d;
            acc_q    <= acc_d;
            stab_q   <= stab_d;
        end
    end

    always_comb begin
        legal = 1'b1;
        dval  = 4'h0;
        unique case (sample_q)
            7'b1000000: dval = 4'h0;
            7'b1111001: dval = 4'h1;
            7'b0100100: dval = 4'h2;
            7'b0110000: dval = 4'h3;
            7'b0011001: dval = 4'h4;
            7'b0010010: dval = 4'h5;
            7'b0000010: dval = 4'h6;
            7'b1111000: dval = 4'h7;
            7'b0000000: dval = 4'h8;
            7'b0010000: dval = 4'h9;
            7'b0001000: dval = 4'hA;
            7'b0000011: dval = 4'hB;
            7'b1000110: dval = 4'hC;
            7'b0100001: dval = 4'hD;
            7'b0000110: dval = 4'hE;
            7'b0001110: dval = 4'hF;
            default:    legal = 1'b0;
        endcase
        if (int'(dval) >= MOD) begin
            legal = 1'b0;
        end
    end

    assign nxt = (int'(value_q) == MOD - 1) ? 4'd0 : value_q + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SYNC;
            value_q  <= 4'd0;
            valid_q  <= 1'b0;
            up_q     <= 1'b0;
            seq_q    <= 1'b0;
            gly_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            up_q  <= 1'b0;
            seq_q <= 1'b0;
            gly_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    SYNC: begin
                        if (legal) begin
                            value_q <= dval;
                            valid_q <= 1'b1;
                            state_q <= TRACK;
                        end else begin
                            gly_q    <= 1'b1;
                            sticky_q <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (!legal) begin
                            gly_q    <= 1'b1;
                            sticky_q <= 1'b1;
                            valid_q  <= 1'b0;
                            state_q  <= SYNC;
                        end else if (dval == nxt) begin
                            up_q    <= 1'b1;
                            value_q <= dval;
                            if (cnt_q != {CNT_W{1'b1}}) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            seq_q    <= 1'b1;
                            sticky_q <= 1'b1;
                            value_q  <= dval;
                        end
                    end
                endcase
            end
        end
    end

    assign value_out    = value_q;
    assign value_valid  = valid_q;
    assign update_pulse = up_q;
    assign seq_err      = seq_q;
    assign glyph_err    = gly_q;
    assign err_sticky   = sticky_q;
    assign update_count = cnt_q;

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Bench for seg7_sequence_checker: MOD=16 and MOD=10 instances on a shared
// segment bus, checked against a sliding-window reference model.
module tb_seg7_sequence_checker;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h7F;

    logic [3:0] vo0, vo1;
    logic       vv0, vv1, up0, up1, se0, se1, ge0, ge1, st0, st1;
    logic [7:0] uc0, uc1;

    int checks = 0;
    int failures = 0;
    int n_up0, n_se0, n_ge0, n_up1, n_se1, n_ge1;

    logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg7_sequence_checker #(.STABLE_CYCLES(S), .MOD(16), .CNT_W(8)) dut16 (
        .clk(clk), .reset(rst_n), .seg_in(seg),
        .value_out(vo0), .value_valid(vv0), .update_pulse(up0),
        .seq_err(se0), .glyph_err(ge0), .err_sticky(st0),
        .update_count(uc0));

    seg7_sequence_checker #(.STABLE_CYCLES(S), .MOD(10), .CNT_W(8)) dut10 (
        .clk(clk), .reset(rst_n), .seg_in(seg),
        .value_out(vo1), .value_valid(vv1), .update_pulse(up1),
        .seq_err(se1), .glyph_err(ge1), .err_sticky(st1),
        .update_count(uc1));

    always #5 clk = ~clk;

    // Reference model: a pattern is accepted once the last S sampled
    // values all agree and differ from the previously accepted pattern.
    logic [6:0] m_hist [2][S];
    int         m_nh   [2];
    logic [6:0] m_acc  [2];
    int         m_val  [2];
    int         m_cnt  [2];
    bit m_valid [2], m_up [2], m_seq [2], m_gly [2], m_st [2];

    function automatic int mdec(logic [6:0] p, int mod);
        for (int k = 0; k < 16; k++)
            if (TBL[k] == p) return (k < mod) ? k : -1;
        return -1;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_nh[i] = 0; m_acc[i] = 7'h7F; m_val[i] = 0; m_cnt[i] = 0;
            m_valid[i] = 0; m_up[i] = 0; m_seq[i] = 0;
            m_gly[i] = 0; m_st[i] = 0;
        end
    endtask

    task automatic mstep(int i, int mod);
        bit same;
        int d;
        m_up[i] = 0; m_seq[i] = 0; m_gly[i] = 0;
        same = (m_nh[i] == S);
        for (int k = 1; k < S; k++)
            if (m_hist[i][k] != m_hist[i][0]) same = 0;
        if (same && m_hist[i][0] != m_acc[i]) begin
            m_acc[i] = m_hist[i][0];
            d = mdec(m_acc[i], mod);
            if (!m_valid[i]) begin
                if (d < 0) begin m_gly[i] = 1; m_st[i] = 1; end
                else begin m_val[i] = d; m_valid[i] = 1; end
            end else if (d < 0) begin
                m_gly[i] = 1; m_st[i] = 1; m_valid[i] = 0;
            end else if (d == (m_val[i] + 1) % mod) begin
                m_up[i] = 1; m_val[i] = d;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else begin
                m_seq[i] = 1; m_st[i] = 1; m_val[i] = d;
            end
        end
        for (int k = S - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = seg;
        if (m_nh[i] < S) m_nh[i]++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else for (int i = 0; i < 2; i++) mstep(i, (i == 0) ? 16 : 10);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        chk("i0 value_out", 32'(vo0), 32'(m_val[0]));
        chk("i0 value_valid", 32'(vv0), 32'(m_valid[0]));
        chk("i0 update_pulse", 32'(up0), 32'(m_up[0]));
        chk("i0 seq_err", 32'(se0), 32'(m_seq[0]));
        chk("i0 glyph_err", 32'(ge0), 32'(m_gly[0]));
        chk("i0 err_sticky", 32'(st0), 32'(m_st[0]));
        chk("i0 update_count", 32'(uc0), 32'(m_cnt[0]));
        chk("i1 value_out", 32'(vo1), 32'(m_val[1]));
        chk("i1 value_valid", 32'(vv1), 32'(m_valid[1]));
        chk("i1 update_pulse", 32'(up1), 32'(m_up[1]));
        chk("i1 seq_err", 32'(se1), 32'(m_seq[1]));
        chk("i1 glyph_err", 32'(ge1), 32'(m_gly[1]));
        chk("i1 err_sticky", 32'(st1), 32'(m_st[1]));
        chk("i1 update_count", 32'(uc1), 32'(m_cnt[1]));
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cmp_model();
            if (up0) n_up0++;
            if (se0) n_se0++;
            if (ge0) n_ge0++;
            if (up1) n_up1++;
            if (se1) n_se1++;
            if (ge1) n_ge1++;
        end
    endtask

    task automatic clr_counts();
        n_up0 = 0; n_se0 = 0; n_ge0 = 0;
        n_up1 = 0; n_se1 = 0; n_ge1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    int r;
    int hold;

    initial begin
        mreset();
        clr_counts();

        // 1: reset held while the bus toggles, then first lock
        repeat (6) begin
            seg = 7'($urandom);
            tick();
        end
        chk("rst value_out", 32'(vo0), 0);
        chk("rst value_valid", 32'(vv0), 0);
        chk("rst err_sticky", 32'(st0), 0);
        chk("rst update_count", 32'(uc0), 0);
        rst_n = 1'b1;
        seg = TBL[0];
        tick(3);
        chk("lock early valid", 32'(vv0), 0);
        tick();
        chk("lock valid", 32'(vv0), 1);
        chk("lock value", 32'(vo0), 0);
        chk("lock no pulse", 32'(up0), 0);
        tick();

        // 2: full count with wrap on the MOD=16 instance
        clr_counts();
        for (int v = 1; v <= 16; v++) begin
            seg = TBL[v % 16];
            tick(10);
        end
        chk("wrap16 pulses", 32'(n_up0), 16);
        chk("wrap16 count", 32'(uc0), 16);
        chk("wrap16 seq_err", 32'(n_se0), 0);
        chk("wrap16 glyph_err", 32'(n_ge0), 0);
        chk("wrap16 sticky", 32'(st0), 0);

        // 3: glitch shorter than the filter window
        for (int v = 1; v <= 3; v++) begin
            seg = TBL[v];
            tick(10);
        end
        clr_counts();
        seg = TBL[5];
        tick(2);
        seg = TBL[3];
        tick(10);
        chk("glitch pulses", 32'(n_up0 + n_se0 + n_ge0), 0);
        chk("glitch value", 32'(vo0), 3);

        // 4: out-of-sequence value, then resume from it
        seg = TBL[5];
        tick(10);
        chk("seq pulses", 32'(n_se0), 1);
        chk("seq sticky", 32'(st0), 1);
        chk("seq value", 32'(vo0), 5);
        chk("seq count", 32'(uc0), 19);
        clr_counts();
        seg = TBL[6];
        tick(10);
        chk("resume pulses", 32'(n_up0), 1);
        chk("resume count", 32'(uc0), 20);

        // 5: blank pattern drops to SYNC, next glyph relocks silently
        clr_counts();
        seg = 7'h7F;
        tick(10);
        chk("blank glyph_err", 32'(n_ge0), 1);
        chk("blank valid", 32'(vv0), 0);
        seg = TBL[7];
        tick(10);
        chk("relock value", 32'(vo0), 7);
        chk("relock valid", 32'(vv0), 1);
        chk("relock no pulse", 32'(n_up0), 0);

        // 6: MOD=10 wrap, out-of-range glyph, asynchronous reset
        do_reset();
        seg = TBL[8];
        tick(10);
        seg = TBL[9];
        tick(10);
        clr_counts();
        seg = TBL[0];
        tick(10);
        chk("wrap10 pulses", 32'(n_up1), 1);
        chk("wrap10 value", 32'(vo1), 0);
        seg = TBL[10];
        tick(10);
        chk("mod10 A glyph_err", 32'(n_ge1), 1);
        chk("mod10 A valid", 32'(vv1), 0);
        chk("mod10 A sticky", 32'(st1), 1);
        seg = TBL[11];
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        cmp_model();
        chk("async sticky", 32'(st1), 0);
        chk("async valid", 32'(vv1), 0);
        chk("async value", 32'(vo1), 0);
        chk("async count16", 32'(uc0), 0);
        tick(2);
        rst_n = 1'b1;

        // counter saturation
        seg = TBL[0];
        tick(5);
        for (int k = 1; k <= 270; k++) begin
            seg = TBL[k % 16];
            tick(4);
        end
        chk("saturate count", 32'(uc0), 255);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            hold = $urandom_range(S, S + 4);
            if (r < 11) seg = TBL[(m_val[0] + 1) % 16];
            else if (r < 14) seg = TBL[$urandom_range(0, 15)];
            else if (r < 16) seg = 7'($urandom);
            else if (r < 19) begin
                seg = TBL[$urandom_range(0, 15)];
                hold = $urandom_range(1, S - 1);
            end else begin
                do_reset();
            end
            tick(hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
